// File: rtl/i2cmb_cmd_sequencer.sv
// Drives the i2cmb Wishbone port to run one I2C transfer per accepted request.
// Build option: define I2CMB_SEQ_IRQ_EN to enable the core interrupt and wait on irq_i instead of polling.
module i2cmb_cmd_sequencer #(
    parameter int unsigned LEN_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_rw_i,
    input  logic [3:0]       req_bus_i,
    input  logic [6:0]       req_addr_i,
    input  logic [LEN_W-1:0] req_len_i,
    input  logic             wdata_valid_i,
    output logic             wdata_ready_o,
    input  logic [7:0]       wdata_i,
    output logic             rdata_valid_o,
    output logic [7:0]       rdata_o,
    output logic             done_o,
    output logic [1:0]       status_o,
    output logic             cyc_o,
    output logic             stb_o,
    output logic             we_o,
    output logic [1:0]       adr_o,
    output logic [7:0]       dat_o,
    input  logic [7:0]       dat_i,
    input  logic             ack_i,
    input  logic             irq_i
);

    localparam logic [1:0] ADR_CSR  = 2'd0;
    localparam logic [1:0] ADR_DPR  = 2'd1;
    localparam logic [1:0] ADR_CMDR = 2'd2;
`ifdef I2CMB_SEQ_IRQ_EN
    localparam logic [7:0] CSR_INIT = 8'hC0;
`else
    localparam logic [7:0] CSR_INIT = 8'h80;
`endif
    localparam logic [1:0] ST_NAK = 2'b01;
    localparam logic [1:0] ST_AL  = 2'b10;
    localparam logic [1:0] ST_ERR = 2'b11;

    typedef enum logic [3:0] {
        S_INIT, S_IDLE, S_SETBUS, S_START, S_ADDR,
        S_WDATA, S_RDATA, S_STOP, S_WAITDON, S_FINISH
    } state_t;

    state_t             state_q, state_d, ret_q, ret_d;
    logic [1:0]         step_q, step_d;
    logic [3:0]         bus_q, bus_d, cache_q, cache_d;
    logic               cache_ok_q, cache_ok_d;
    logic [6:0]         addr_q, addr_d;
    logic               rw_q, rw_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         err_q, err_d;
    logic               req_ready_q, req_ready_d, wdata_ready_q, wdata_ready_d;
    logic               rdata_valid_q, rdata_valid_d, done_q, done_d;
    logic [7:0]         rdata_q, rdata_d, dat_q, dat_d;
    logic [1:0]         status_q, status_d, adr_q, adr_d;
    logic               cyc_q, cyc_d, we_q, we_d;
    logic               go, go_we, acked;
    logic [1:0]         go_adr;
    logic [7:0]         go_dat;

`ifndef I2CMB_SEQ_IRQ_EN
    logic unused_irq;
    assign unused_irq = irq_i;
`endif

    assign acked = cyc_q && ack_i;

    // Next-state logic; each state requests at most one Wishbone access via go/go_*.
    always_comb begin
        state_d       = state_q;
        ret_d         = ret_q;
        step_d        = step_q;
        bus_d         = bus_q;
        addr_d        = addr_q;
        rw_d          = rw_q;
        cnt_d         = cnt_q;
        cache_d       = cache_q;
        cache_ok_d    = cache_ok_q;
        err_d         = err_q;
        rdata_valid_d = 1'b0;
        rdata_d       = rdata_q;
        done_d        = 1'b0;
        status_d      = status_q;
        cyc_d         = cyc_q;
        we_d          = we_q;
        adr_d         = adr_q;
        dat_d         = dat_q;
        go            = 1'b0;
        go_we         = 1'b1;
        go_adr        = ADR_CSR;
        go_dat        = 8'h00;
        if (acked) begin
            cyc_d = 1'b0;
            we_d  = 1'b0;
        end

        case (state_q)
            S_INIT: begin
                go     = 1'b1;
                go_dat = CSR_INIT;
                if (acked) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (req_valid_i && req_ready_q) begin
                    bus_d   = req_bus_i;
                    addr_d  = req_addr_i;
                    rw_d    = req_rw_i;
                    cnt_d   = req_len_i;
                    err_d   = 2'b00;
                    step_d  = 2'd0;
                    state_d = (cache_ok_q && cache_q == req_bus_i) ? S_START : S_SETBUS;
                end
            end
            S_SETBUS: begin
                case (step_q)
                    2'd0: begin
                        go = 1'b1; go_adr = ADR_DPR; go_dat = {4'h0, bus_q};
                        if (acked) step_d = 2'd1;
                    end
                    2'd1: begin
                        go = 1'b1; go_adr = ADR_CMDR; go_dat = 8'h06;
                        if (acked) begin step_d = 2'd2; ret_d = S_SETBUS; state_d = S_WAITDON; end
                    end
                    default: begin
                        cache_d = bus_q; cache_ok_d = 1'b1; step_d = 2'd0; state_d = S_START;
                    end
                endcase
            end
            S_START: begin
                if (step_q == 2'd0) begin
                    go = 1'b1; go_adr = ADR_CMDR; go_dat = 8'h04;
                    if (acked) begin step_d = 2'd1; ret_d = S_START; state_d = S_WAITDON; end
                end else begin
                    step_d = 2'd0; state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                case (step_q)
                    2'd0: begin
                        go = 1'b1; go_adr = ADR_DPR; go_dat = {addr_q, rw_q};
                        if (acked) step_d = 2'd1;
                    end
                    2'd1: begin
                        go = 1'b1; go_adr = ADR_CMDR; go_dat = 8'h01;
                        if (acked) begin step_d = 2'd2; ret_d = S_ADDR; state_d = S_WAITDON; end
                    end
                    default: begin
                        step_d  = 2'd0;
                        state_d = (cnt_q == LEN_W'(0)) ? S_STOP : (rw_q ? S_RDATA : S_WDATA);
                    end
                endcase
            end
            S_WDATA: begin
                case (step_q)
                    2'd0: begin
                        // Bus stays idle until the requester supplies the byte.
                        go = wdata_valid_i && wdata_ready_q; go_adr = ADR_DPR; go_dat = wdata_i;
                        if (acked) step_d = 2'd1;
                    end
                    2'd1: begin
                        go = 1'b1; go_adr = ADR_CMDR; go_dat = 8'h01;
                        if (acked) begin step_d = 2'd2; ret_d = S_WDATA; state_d = S_WAITDON; end
                    end
                    default: begin
                        cnt_d   = cnt_q - LEN_W'(1);
                        step_d  = 2'd0;
                        state_d = (cnt_q == LEN_W'(1)) ? S_STOP : S_WDATA;
                    end
                endcase
            end
            S_RDATA: begin
                if (step_q == 2'd0) begin
                    go = 1'b1; go_adr = ADR_CMDR;
                    go_dat = (cnt_q == LEN_W'(1)) ? 8'h03 : 8'h02;
                    if (acked) begin step_d = 2'd1; ret_d = S_RDATA; state_d = S_WAITDON; end
                end else begin
                    go = 1'b1; go_we = 1'b0; go_adr = ADR_DPR;
                    if (acked) begin
                        rdata_d       = dat_i;
                        rdata_valid_d = 1'b1;
                        cnt_d         = cnt_q - LEN_W'(1);
                        step_d        = 2'd0;
                        state_d       = (cnt_q == LEN_W'(1)) ? S_STOP : S_RDATA;
                    end
                end
            end
            S_STOP: begin
                go = 1'b1; go_adr = ADR_CMDR; go_dat = 8'h05;
                if (acked) begin ret_d = S_STOP; state_d = S_WAITDON; end
            end
            S_WAITDON: begin
`ifdef I2CMB_SEQ_IRQ_EN
                go = irq_i;
`else
                go = 1'b1;
`endif
                go_we = 1'b0; go_adr = ADR_CMDR;
                // No status bit set yet: stay and read again after the idle cycle.
                if (acked) begin
                    if (dat_i[7] || (dat_i[6] && ret_q == S_STOP)) begin
                        if (ret_q == S_STOP) begin
                            state_d = S_FINISH; done_d = 1'b1; status_d = err_q;
                        end else begin
                            state_d = ret_q;
                        end
                    end else if (dat_i[6]) begin
                        err_d = ST_NAK; step_d = 2'd0; state_d = S_STOP;
                    end else if (dat_i[5]) begin
                        status_d = ST_AL; done_d = 1'b1; cache_ok_d = 1'b0; state_d = S_FINISH;
                    end else if (dat_i[4]) begin
                        status_d = ST_ERR; done_d = 1'b1; cache_ok_d = 1'b0; state_d = S_FINISH;
                    end
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_INIT;
        endcase

        if (go && !cyc_q) begin
            cyc_d = 1'b1;
            we_d  = go_we;
            adr_d = go_adr;
            if (go_we) dat_d = go_dat;
        end

        req_ready_d   = (state_d == S_IDLE);
        wdata_ready_d = (state_d == S_WDATA) && (step_d == 2'd0) && !cyc_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_INIT;
            ret_q         <= S_IDLE;
            step_q        <= 2'd0;
            bus_q         <= 4'h0;
            addr_q        <= 7'h00;
            rw_q          <= 1'b0;
            cnt_q         <= '0;
            cache_q       <= 4'h0;
            cache_ok_q    <= 1'b0;
            err_q         <= 2'b00;
            req_ready_q   <= 1'b0;
            wdata_ready_q <= 1'b0;
            rdata_valid_q <= 1'b0;
            rdata_q       <= 8'h00;
            done_q        <= 1'b0;
            status_q      <= 2'b00;
            cyc_q         <= 1'b0;
            we_q          <= 1'b0;
            adr_q         <= 2'd0;
            dat_q         <= 8'h00;
        end else begin
            state_q       <= state_d;
            ret_q         <= ret_d;
            step_q        <= step_d;
            bus_q         <= bus_d;
            addr_q        <= addr_d;
            rw_q          <= rw_d;
            cnt_q         <= cnt_d;
            cache_q       <= cache_d;
            cache_ok_q    <= cache_ok_d;
            err_q         <= err_d;
            req_ready_q   <= req_ready_d;
            wdata_ready_q <= wdata_ready_d;
            rdata_valid_q <= rdata_valid_d;
            rdata_q       <= rdata_d;
            done_q        <= done_d;
            status_q      <= status_d;
            cyc_q         <= cyc_d;
            we_q          <= we_d;
            adr_q         <= adr_d;
            dat_q         <= dat_d;
        end
    end

    assign req_ready_o   = req_ready_q;
    assign wdata_ready_o = wdata_ready_q;
    assign rdata_valid_o = rdata_valid_q;
    assign rdata_o       = rdata_q;
    assign done_o        = done_q;
    assign status_o      = status_q;
    assign cyc_o         = cyc_q;
    assign stb_o         = cyc_q;
    assign we_o          = we_q;
    assign adr_o         = adr_q;
    assign dat_o         = dat_q;

endmodule

// File: tb/tb_i2cmb_cmd_sequencer.sv
// Bench for i2cmb_cmd_sequencer: behavioural i2cmb slave, transfer-level reference model, random transfers.
module tb_i2cmb_cmd_sequencer;
    localparam int unsigned LEN_W = 4;
`ifdef I2CMB_SEQ_IRQ_EN
    localparam logic [7:0] CSR_VAL = 8'hC0;
`else
    localparam logic [7:0] CSR_VAL = 8'h80;
`endif

    logic clk = 1'b0;
    logic rst_i, req_valid_i, req_ready_o, req_rw_i;
    logic [3:0] req_bus_i;
    logic [6:0] req_addr_i;
    logic [LEN_W-1:0] req_len_i;
    logic wdata_valid_i, wdata_ready_o, rdata_valid_o, done_o;
    logic [7:0] wdata_i, rdata_o, dat_o, dat_i;
    logic [1:0] status_o, adr_o;
    logic cyc_o, stb_o, we_o, ack_i, irq_i;

    i2cmb_cmd_sequencer #(.LEN_W(LEN_W)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_rw_i(req_rw_i),
        .req_bus_i(req_bus_i), .req_addr_i(req_addr_i), .req_len_i(req_len_i),
        .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o), .wdata_i(wdata_i),
        .rdata_valid_o(rdata_valid_o), .rdata_o(rdata_o), .done_o(done_o), .status_o(status_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
        .dat_i(dat_i), .ack_i(ack_i), .irq_i(irq_i)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave model state
    bit         inj_nak, inj_al, addr_phase, dpr_rd_flag, hs_pend, prev_cyc, last_done;
    int         wait_cnt, polls, viol, done_cnt, wcons;
    logic [7:0] res, rd_next, rd_cur, rd_val;
    logic [10:0] prev_bus;
    logic [9:0] wlog[$];
    logic [7:0] rq[$];
    logic [7:0] wq[$];

    // Monitor, i2cmb slave model and write-byte feeder, all evaluated away from the active edge.
    always @(negedge clk) begin
        if (!rst_i) begin
            if (ack_i && (cyc_o || we_o)) viol++;
            if (prev_cyc && !ack_i && cyc_o && ({adr_o, we_o, dat_o} != prev_bus)) viol++;
            if (dpr_rd_flag != rdata_valid_o) viol++;
            if (dpr_rd_flag && rdata_o != rd_val) viol++;
            if (last_done && !req_ready_o) viol++;
            if (done_o && req_ready_o) viol++;
            if (wdata_ready_o && cyc_o) viol++;
            if (cyc_o != stb_o) viol++;
        end
        if (rdata_valid_o) rq.push_back(rdata_o);
        if (done_o) done_cnt++;
        last_done = done_o;
        prev_cyc  = cyc_o;
        prev_bus  = {adr_o, we_o, dat_o};

        dpr_rd_flag = 1'b0;
        if (rst_i) begin
            ack_i = 1'b0; wait_cnt = 0; irq_i = 1'b0; hs_pend = 1'b0;
        end else if (cyc_o && stb_o && !ack_i) begin
            if (wait_cnt > 0) wait_cnt--;
            else begin
                ack_i = 1'b1;
                if (we_o) begin
                    wlog.push_back({adr_o, dat_o});
                    if (adr_o == 2'd2) begin
`ifdef I2CMB_SEQ_IRQ_EN
                        polls = 0;
                        irq_i = 1'b1;
`else
                        polls = $urandom_range(0, 3);
`endif
                        res = 8'h80;
                        if (dat_o == 8'h04) begin
                            addr_phase = 1'b1;
                            if (inj_al) res = 8'h20;
                        end else if (dat_o == 8'h01) begin
                            if (inj_nak && addr_phase) res = 8'h40;
                            addr_phase = 1'b0;
                        end else if (dat_o == 8'h02 || dat_o == 8'h03) begin
                            rd_cur  = rd_next;
                            rd_next = rd_next + 8'd1;
                        end
                    end
                end else begin
                    if (adr_o == 2'd2) begin
                        irq_i = 1'b0;
                        if (polls > 0) begin polls--; dat_i = 8'h00; end
                        else dat_i = res;
                    end else if (adr_o == 2'd1) begin
                        dat_i = rd_cur; rd_val = rd_cur; dpr_rd_flag = 1'b1;
                    end else dat_i = 8'h00;
                end
            end
        end else begin
            ack_i = 1'b0;
            wait_cnt = $urandom_range(0, 2);
        end

        if (hs_pend && wq.size() > 0) begin
            void'(wq.pop_front());
            wcons++;
        end
        if (!wdata_valid_i || hs_pend) wdata_valid_i = (wq.size() > 0) && ($urandom_range(0, 2) != 0);
        if (wq.size() == 0) wdata_valid_i = 1'b0;
        else wdata_i = wq[0];
        hs_pend = !rst_i && wdata_valid_i && wdata_ready_o;
    end

    // Transfer-level reference model
    logic [3:0] ref_cache;
    bit         ref_cache_ok;
    logic [9:0] exp_q[$];
    logic [1:0] exp_status;
    logic [7:0] tx_bytes[$];

    task automatic build_expected(input bit rw, input logic [3:0] bus, input logic [6:0] addr,
                                  input int len, input bit nak, input bit al);
        exp_q.delete();
        if (!(ref_cache_ok && ref_cache == bus)) begin
            exp_q.push_back({2'd1, 4'h0, bus});
            exp_q.push_back({2'd2, 8'h06});
            ref_cache = bus;
            ref_cache_ok = 1'b1;
        end
        exp_q.push_back({2'd2, 8'h04});
        if (al) begin
            ref_cache_ok = 1'b0;
            exp_status = 2'b10;
            return;
        end
        exp_q.push_back({2'd1, addr, rw});
        exp_q.push_back({2'd2, 8'h01});
        if (!nak) begin
            for (int i = 0; i < len; i++) begin
                if (rw) exp_q.push_back({2'd2, (i == len - 1) ? 8'h03 : 8'h02});
                else begin
                    exp_q.push_back({2'd1, tx_bytes[i]});
                    exp_q.push_back({2'd2, 8'h01});
                end
            end
        end
        exp_q.push_back({2'd2, 8'h05});
        exp_status = nak ? 2'b01 : 2'b00;
    endtask

    task automatic send_req(input bit rw, input logic [3:0] bus, input logic [6:0] addr, input int len);
        int n = 0;
        req_rw_i = rw; req_bus_i = bus; req_addr_i = addr; req_len_i = LEN_W'(len);
        req_valid_i = 1'b1;
        while (!req_ready_o && n < 500) begin @(negedge clk); n++; end
        check("req_accept", {31'd0, req_ready_o}, 1);
        @(negedge clk);
        req_valid_i = 1'b0;
    endtask

    task automatic do_xfer(input bit rw, input logic [3:0] bus, input logic [6:0] addr, input int len,
                           input bit nak, input bit al, input logic [7:0] base);
        int n = 0;
        int d0;
        int m;
        int exp_rd;
        build_expected(rw, bus, addr, len, nak, al);
        exp_rd  = (rw && !nak && !al) ? len : 0;
        inj_nak = nak; inj_al = al; rd_next = base;
        wlog.delete(); rq.delete(); wcons = 0; d0 = done_cnt;
        if (!rw) wq = tx_bytes;
        send_req(rw, bus, addr, len);
        while (done_cnt == d0 && n < 4000) begin @(negedge clk); n++; end
        check("done_seen", {31'd0, done_cnt != d0}, 1);
        repeat (4) @(negedge clk);
        check("done_count", done_cnt - d0, 1);
        check("status", {30'd0, status_o}, {30'd0, exp_status});
        check("wb_count", wlog.size(), exp_q.size());
        m = (wlog.size() < exp_q.size()) ? wlog.size() : exp_q.size();
        for (int i = 0; i < m; i++) check("wb_seq", {22'd0, wlog[i]}, {22'd0, exp_q[i]});
        check("rd_count", rq.size(), exp_rd);
        for (int i = 0; i < rq.size() && i < exp_rd; i++) check("rd_data", {24'd0, rq[i]}, {24'd0, 8'(base + 8'(i))});
        check("wr_consumed", wcons, (!rw && !nak && !al) ? len : 0);
        wq.delete();
        inj_nak = 1'b0; inj_al = 1'b0;
    endtask

    task automatic wait_ready(input int lim);
        int n = 0;
        while (!req_ready_o && n < lim) begin @(negedge clk); n++; end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int d0;
        logic [9:0] first;
        rst_i = 1'b1; req_valid_i = 1'b0; req_rw_i = 1'b0; req_bus_i = '0; req_addr_i = '0;
        req_len_i = '0; wdata_valid_i = 1'b0; wdata_i = '0; dat_i = '0; ack_i = 1'b0; irq_i = 1'b0;
        ref_cache_ok = 1'b0; ref_cache = '0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready_o}, 0);
        check("rst_wdata_ready", {31'd0, wdata_ready_o}, 0);
        check("rst_rdata_valid", {31'd0, rdata_valid_o}, 0);
        check("rst_done", {31'd0, done_o}, 0);
        check("rst_status", {30'd0, status_o}, 0);
        check("rst_wb_ctl", {29'd0, cyc_o, stb_o, we_o}, 0);
        check("rst_adr_dat", {22'd0, adr_o, dat_o}, 0);
        wlog.delete();
        rst_i = 1'b0;
        wait_ready(100);
        check("init_ready", {31'd0, req_ready_o}, 1);
        check("init_wb_count", wlog.size(), 1);
        first = (wlog.size() > 0) ? wlog[0] : 10'h3FF;
        check("init_csr", {22'd0, first}, {22'd0, 2'd0, CSR_VAL});
        check("idle_done", {31'd0, done_o}, 0);

        tx_bytes = {8'hA5, 8'h5A};
        do_xfer(1'b0, 4'd2, 7'h22, 2, 1'b0, 1'b0, 8'h00);
        do_xfer(1'b1, 4'd2, 7'h22, 3, 1'b0, 1'b0, 8'h10);
        tx_bytes = {8'h77, 8'h88};
        do_xfer(1'b0, 4'd2, 7'h33, 2, 1'b1, 1'b0, 8'h00);
        tx_bytes = {8'h99};
        do_xfer(1'b0, 4'd2, 7'h11, 1, 1'b0, 1'b1, 8'h00);
        do_xfer(1'b1, 4'd2, 7'h11, 1, 1'b0, 1'b0, 8'h40);
        do_xfer(1'b1, 4'd2, 7'h50, 0, 1'b0, 1'b0, 8'h00);

        for (int t = 0; t < 14; t++) begin
            bit rw, nak, al;
            int len;
            rw  = 1'($urandom_range(0, 1));
            len = (t == 0) ? 15 : $urandom_range(0, 5);
            nak = ($urandom_range(0, 6) == 0);
            al  = !nak && ($urandom_range(0, 6) == 0);
            tx_bytes.delete();
            for (int i = 0; i < len; i++) tx_bytes.push_back(8'($urandom));
            do_xfer(rw, 4'($urandom_range(0, 3)), 7'($urandom), len, nak, al, 8'($urandom));
        end

        // Reset while the first data byte write is on the bus
        tx_bytes = {8'h01, 8'h02, 8'h03};
        wq = tx_bytes; wlog.delete(); d0 = done_cnt;
        send_req(1'b0, 4'd3, 7'h40, 3);
        n = 0;
        while (!(cyc_o && stb_o && we_o && adr_o == 2'd1 && dat_o == 8'h01) && n < 2000) begin
            @(negedge clk); n++;
        end
        check("rst_reach_wdata", {31'd0, n < 2000}, 1);
        rst_i = 1'b1;
        @(negedge clk);
        check("rst_cyc_drop", {30'd0, cyc_o, stb_o}, 0);
        @(negedge clk);
        wlog.delete(); wq.delete(); ref_cache_ok = 1'b0;
        rst_i = 1'b0;
        wait_ready(100);
        check("rst_no_done", done_cnt - d0, 0);
        check("rst_init_count", wlog.size(), 1);
        first = (wlog.size() > 0) ? wlog[0] : 10'h3FF;
        check("rst_init_csr", {22'd0, first}, {22'd0, 2'd0, CSR_VAL});
        tx_bytes = {8'h5C};
        do_xfer(1'b0, 4'd3, 7'h40, 1, 1'b0, 1'b0, 8'h00);

        check("wb_protocol", viol, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
